// File: rtl/mips_isa_pkg.sv
// Shared MIPS-I subset definitions: mnemonic ids, opcode/funct constants and
// field-packing helpers, used by the instruction encoder and the control decoder.
package mips_isa_pkg;

    typedef enum logic [4:0] {
        MN_ADD   = 5'd0,  MN_SUB   = 5'd1,  MN_AND   = 5'd2,  MN_OR    = 5'd3,
        MN_XOR   = 5'd4,  MN_NOR   = 5'd5,  MN_SLT   = 5'd6,  MN_SLTU  = 5'd7,
        MN_SLLV  = 5'd8,  MN_SRLV  = 5'd9,  MN_SRAV  = 5'd10, MN_SLL   = 5'd11,
        MN_SRL   = 5'd12, MN_SRA   = 5'd13, MN_JR    = 5'd14, MN_BEQ   = 5'd15,
        MN_BNE   = 5'd16, MN_ADDI  = 5'd17, MN_SLTI  = 5'd18, MN_SLTIU = 5'd19,
        MN_ANDI  = 5'd20, MN_ORI   = 5'd21, MN_XORI  = 5'd22, MN_LUI   = 5'd23,
        MN_LW    = 5'd24, MN_SW    = 5'd25, MN_J     = 5'd26, MN_JAL   = 5'd27
    } mnem_t;

    localparam int NUM_MNEM = 28;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_SLTI    = 6'b001010;
    localparam logic [5:0] OP_SLTIU   = 6'b001011;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {OP_SPECIAL, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] target);
        return {op, target};
    endfunction

endpackage

// File: rtl/instr_word_builder.sv
// Combinational encoder: mnemonic id plus raw fields to a 32-bit MIPS word.
// Fields a format does not use are dropped here rather than by the requester.
module instr_word_builder
    import mips_isa_pkg::*;
(
    input  logic [4:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        legal
);

    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (mnem_t'(mnem))
            MN_ADD:   word = rtype(rs, rt, rd, 5'd0, FN_ADD);
            MN_SUB:   word = rtype(rs, rt, rd, 5'd0, FN_SUB);
            MN_AND:   word = rtype(rs, rt, rd, 5'd0, FN_AND);
            MN_OR:    word = rtype(rs, rt, rd, 5'd0, FN_OR);
            MN_XOR:   word = rtype(rs, rt, rd, 5'd0, FN_XOR);
            MN_NOR:   word = rtype(rs, rt, rd, 5'd0, FN_NOR);
            MN_SLT:   word = rtype(rs, rt, rd, 5'd0, FN_SLT);
            MN_SLTU:  word = rtype(rs, rt, rd, 5'd0, FN_SLTU);
            MN_SLLV:  word = rtype(rs, rt, rd, 5'd0, FN_SLLV);
            MN_SRLV:  word = rtype(rs, rt, rd, 5'd0, FN_SRLV);
            MN_SRAV:  word = rtype(rs, rt, rd, 5'd0, FN_SRAV);
            // Immediate shifts carry the amount in shamt; rs is not part of the word.
            MN_SLL:   word = rtype(5'd0, rt, rd, shamt, FN_SLL);
            MN_SRL:   word = rtype(5'd0, rt, rd, shamt, FN_SRL);
            MN_SRA:   word = rtype(5'd0, rt, rd, shamt, FN_SRA);
            MN_JR:    word = rtype(rs, 5'd0, 5'd0, 5'd0, FN_JR);
            MN_BEQ:   word = itype(OP_BEQ, rs, rt, imm);
            MN_BNE:   word = itype(OP_BNE, rs, rt, imm);
            MN_ADDI:  word = itype(OP_ADDI, rs, rt, imm);
            MN_SLTI:  word = itype(OP_SLTI, rs, rt, imm);
            MN_SLTIU: word = itype(OP_SLTIU, rs, rt, imm);
            MN_ANDI:  word = itype(OP_ANDI, rs, rt, imm);
            MN_ORI:   word = itype(OP_ORI, rs, rt, imm);
            MN_XORI:  word = itype(OP_XORI, rs, rt, imm);
            MN_LUI:   word = itype(OP_LUI, 5'd0, rt, imm);
            MN_LW:    word = itype(OP_LW, rs, rt, imm);
            MN_SW:    word = itype(OP_SW, rs, rt, imm);
            MN_J:     word = jtype(OP_J, target);
            MN_JAL:   word = jtype(OP_JAL, target);
            default:  legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Accepts instruction descriptions and writes their encodings to consecutive
// instruction-memory words, one word per two cycles, until capacity is reached.
module instr_encoder
    import mips_isa_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h00000000,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [15:0] count,
    output logic        full,
    output logic        err,
    output logic [1:0]  dbg_state
);

    // Handshake: a request transfers on a rising edge where in_valid && in_ready;
    // in_ready is high only in IDLE and does not depend on in_valid.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FULL  = 2'd2
    } enc_state_t;

    localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

    enc_state_t  state, state_next;
    logic [31:0] word;
    logic        legal;
    logic        accept;
    logic        last_word;

    instr_word_builder u_builder (
        .mnem   (mnem),
        .rs     (rs),
        .rt     (rt),
        .rd     (rd),
        .shamt  (shamt),
        .imm    (imm),
        .target (target),
        .word   (word),
        .legal  (legal)
    );

    assign in_ready  = (state == ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign last_word = ({16'd0, count} + 32'd1) >= MAX_W;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (accept && legal) state_next = ST_WRITE;
            ST_WRITE: state_next = last_word ? ST_FULL : ST_IDLE;
            ST_FULL:  state_next = ST_FULL;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            count     <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
        end else begin
            state <= state_next;
            err   <= accept && !legal;
            if (accept && legal) mem_wdata <= word;
            if (state == ST_WRITE) count <= count + 16'd1;
        end
    end

    // Strobe and address follow state/count directly so reset clears them at once.
    assign mem_we    = (state == ST_WRITE);
    assign mem_addr  = BASE_ADDR + {14'd0, count, 2'b00};
    assign full      = (state == ST_FULL);
    assign dbg_state = state;

endmodule
